keypad_event_encoder: RTL and testbench
=======================================

Name: keypad_event_encoder

Overview:
- Front-panel input block for the microwave controller. Samples the raw digit keypad (keys 0-9) and debounces each key independently.
- Converts each accepted press into a single 4-bit key code, delivered on a valid/ready handshake to the timer-setting logic.
- Enforces n-key lockout: one event per press, and no new event until every key is released.
- Reports dropped and ambiguous presses through sticky flags.

Parameters:
- NUM_KEYS, 10: number of keypad lines. Key index equals the emitted code.
- STABLE_CYCLES, 4: consecutive synchronized cycles a key must differ from its debounced state before that state flips. Range 1..7.
- CODE_W, 4: width of the code output. Must satisfy 2^CODE_W >= NUM_KEYS.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- clear, input, 1: asynchronous reset, active-high.
- keys, input, NUM_KEYS: raw, asynchronous key levels, 1 = pressed.
- ready, input, 1: consumer accepts code this cycle.
- flags_clr, input, 1: synchronous clear of overrun and multi.
- code, output, CODE_W: index of the accepted key. Stable while valid=1.
- valid, output, 1: code holds an unconsumed event.
- pressed, output, 1: at least one key is debounced-pressed.
- overrun, output, 1: sticky. A press was dropped because valid was still 1.
- multi, output, 1: sticky. More than one key debounced-pressed at acceptance.

Behaviour:
- Reset (clear=1, asynchronous):
  - All outputs go to 0.
  - Synchronizers, debounced states and stability counters go to 0.
  - FSM goes to IDLE.
  - Reset mid-event discards any pending code.
- Synchronizer: each key passes through a 2-flop synchronizer, s1 then s2. Only s2 is used downstream.
- Per-key debounce (3-bit counter):
  - If s2 differs from db, cnt increments.
  - When cnt would reach STABLE_CYCLES, db flips and cnt returns to 0.
  - If s2 equals db, cnt resets to 0. Any glitch restarts the count.
  - Releases are debounced identically.
- FSM, states IDLE and HELD:
  - IDLE -> HELD when any db bit is 1.
    - On that same edge, the event for the lowest-index pressed key is generated.
    - If two or more db bits are 1 on that edge, multi is set.
  - HELD -> IDLE when all db bits are 0.
  - While in HELD, additional presses generate no events.
- Event generation:
  - If valid=0: code takes the key index and valid becomes 1 on the transition edge.
  - If valid=1 and ready=0 on the transition edge: the new event is dropped, code is retained, and overrun is set.
  - If valid=1 and ready=1 on the transition edge: the old event is consumed and the new one loads. valid stays 1 and overrun is not set.
- Handshake:
  - A transfer occurs on any edge where valid and ready are both 1.
  - valid falls on that edge unless a new event loads on the same edge.
  - code must not change while valid=1 without a transfer.
- Latency: for a key rising cleanly, with all other keys idle and valid=0, valid rises at the (STABLE_CYCLES+3)th rising edge after the first edge that samples the key high. That is edge 7 at the default.
- pressed is the registered OR of db, so it rises on the same edge db flips.
- flags_clr=1 clears overrun and multi. If set and clear occur on the same edge, set wins.
- Widths: the counter saturation comparison uses 3 bits. The code is the binary index, zero-extended to CODE_W.

Test Plan:
- Clean press: raise keys[5] and hold for 20 cycles with ready=0.
  - valid=1 and code=5 at edge 7.
  - valid stays 1 with code stable.
  - Pulse ready for 1 cycle: valid=0 on the next edge.
- Glitch rejection: keys[3] high for 3 cycles, low for 1, high for 3, then low.
  - No event is generated.
  - valid and pressed remain 0 throughout.
- Lockout and release: hold keys[2], then add keys[7] while in HELD, with ready=1 throughout.
  - Exactly one event, code=2.
  - Release both, wait 10 cycles, press keys[7]: a second event with code=7.
- Overrun: with ready=0, press and release keys[1], then press keys[4].
  - code stays 1 and overrun=1.
  - Assert flags_clr: overrun=0 on the next edge.
- Simultaneous press: raise keys[9] and keys[0] on the same cycle.
  - code=0 and multi=1.
- Reset mid-operation: assert clear asynchronously between clock edges while valid=1.
  - valid, code and pressed go to 0 immediately, without waiting for an edge.
  - After release of clear with keys held, a fresh event arrives 7 edges later.

Source files
------------

// File: rtl/keypad_event_encoder.sv
// Digit keypad front end: per-key sync and debounce, n-key lockout,
// and a one-deep key-code event register with a valid/ready handshake.
`timescale 1ns/1ps
module keypad_event_encoder #(
  parameter int NUM_KEYS      = 10,
  parameter int STABLE_CYCLES = 4,
  parameter int CODE_W        = 4
) (
  input  logic                clk,
  input  logic                clear,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                ready,
  input  logic                flags_clr,
  output logic [CODE_W-1:0]   code,
  output logic                valid,
  output logic                pressed,
  output logic                overrun,
  output logic                multi
);

  localparam logic [2:0] STB = 3'(STABLE_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_e;

  logic [NUM_KEYS-1:0]      s1_q, s2_q;
  logic [NUM_KEYS-1:0]      db_q, db_d;
  logic [NUM_KEYS-1:0][2:0] cnt_q, cnt_d;
  state_e                   state_q, state_d;
  logic [CODE_W-1:0]        code_q, code_d;
  logic                     valid_q, valid_d;
  logic                     pressed_q;
  logic                     overrun_q, overrun_d;
  logic                     multi_q, multi_d;

  logic [CODE_W-1:0]        lo_idx;
  logic                     any_db;
  logic                     many_db;
  logic                     ev;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= keys;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] + 3'd1 == STB) begin
          db_d[i]  = ~db_q[i];
          cnt_d[i] = 3'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 3'd1;
        end
      end else begin
        cnt_d[i] = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      db_q      <= '0;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      pressed_q <= |db_d;
    end
  end

  // Lowest-index pressed key wins
  always_comb begin
    lo_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (db_q[i]) lo_idx = CODE_W'(i);
    end
  end

  assign any_db  = |db_q;
  assign many_db = |(db_q & (db_q - NUM_KEYS'(1)));

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    multi_d   = multi_q;
    ev        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_db) begin
          state_d = HELD;
          ev      = 1'b1;
        end
      end
      HELD: begin
        if (!any_db) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (valid_q && ready) valid_d = 1'b0;

    if (flags_clr) begin
      overrun_d = 1'b0;
      multi_d   = 1'b0;
    end

    // Set beats a same-edge flags_clr
    if (ev) begin
      if (!valid_q || ready) begin
        code_d  = lo_idx;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
      if (many_db) multi_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      multi_q   <= multi_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pressed = pressed_q;
  assign overrun = overrun_q;
  assign multi   = multi_q;

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Directed bench for keypad_event_encoder.
`timescale 1ns/1ps
module tb_keypad_event_encoder;

  logic       clk;
  logic       clear;
  logic [9:0] keys;
  logic       ready;
  logic       flags_clr;
  logic [3:0] code;
  logic       valid;
  logic       pressed;
  logic       overrun;
  logic       multi;

  int total;
  int bad;

  keypad_event_encoder #(
    .NUM_KEYS(10),
    .STABLE_CYCLES(4),
    .CODE_W(4)
  ) dut (
    .clk(clk),
    .clear(clear),
    .keys(keys),
    .ready(ready),
    .flags_clr(flags_clr),
    .code(code),
    .valid(valid),
    .pressed(pressed),
    .overrun(overrun),
    .multi(multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int          evs;
  logic [3:0]  seen;
  logic        act;

  initial begin
    total     = 0;
    bad       = 0;
    clear     = 1'b1;
    keys      = '0;
    ready     = 1'b0;
    flags_clr = 1'b0;
    tick(2);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_flags", {30'd0, overrun, multi}, 32'd0);
    clear = 1'b0;
    tick(2);

    // clean press on key 5
    keys[5] = 1'b1;
    tick(6);
    chk("p5_pressed_e6", 32'(pressed), 32'd1);
    chk("p5_valid_e6", 32'(valid), 32'd0);
    tick(1);
    chk("p5_valid_e7", 32'(valid), 32'd1);
    chk("p5_code_e7", 32'(code), 32'd5);
    tick(13);
    chk("p5_valid_hold", 32'(valid), 32'd1);
    chk("p5_code_hold", 32'(code), 32'd5);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    chk("p5_consumed", 32'(valid), 32'd0);
    keys[5] = 1'b0;
    tick(10);
    chk("p5_released", 32'(pressed), 32'd0);

    // glitchy key 3
    act = 1'b0;
    keys[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(1); act |= valid | pressed; end
    keys[3] = 1'b0;
    tick(1); act |= valid | pressed;
    keys[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(1); act |= valid | pressed; end
    keys[3] = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(1); act |= valid | pressed; end
    chk("glitch_quiet", 32'(act), 32'd0);

    // lockout: key 2, then key 7 while held
    ready = 1'b1;
    evs   = 0;
    seen  = 4'hf;
    keys[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (valid) begin evs++; seen = code; end
    end
    keys[7] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      if (valid) begin evs++; seen = code; end
    end
    keys[2] = 1'b0;
    keys[7] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (valid) begin evs++; seen = code; end
    end
    chk("lock_events", 32'(evs), 32'd1);
    chk("lock_code", 32'(seen), 32'd2);
    chk("lock_multi", 32'(multi), 32'd0);
    keys[7] = 1'b1;
    tick(7);
    chk("lock_k7_valid", 32'(valid), 32'd1);
    chk("lock_k7_code", 32'(code), 32'd7);
    tick(1);
    chk("lock_k7_taken", 32'(valid), 32'd0);
    keys[7] = 1'b0;
    ready = 1'b0;
    tick(10);

    // overrun: key 1 unconsumed, then key 4
    keys[1] = 1'b1;
    tick(7);
    chk("ov_k1_code", 32'(code), 32'd1);
    keys[1] = 1'b0;
    tick(10);
    keys[4] = 1'b1;
    tick(6);
    chk("ov_before", 32'(overrun), 32'd0);
    tick(1);
    chk("ov_set", 32'(overrun), 32'd1);
    chk("ov_code_kept", 32'(code), 32'd1);
    chk("ov_valid_kept", 32'(valid), 32'd1);
    flags_clr = 1'b1;
    tick(1);
    flags_clr = 1'b0;
    chk("ov_cleared", 32'(overrun), 32'd0);
    chk("ov_code_after", 32'(code), 32'd1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    chk("ov_drained", 32'(valid), 32'd0);
    keys[4] = 1'b0;
    tick(10);

    // simultaneous keys 9 and 0
    keys[9] = 1'b1;
    keys[0] = 1'b1;
    tick(7);
    chk("sim_valid", 32'(valid), 32'd1);
    chk("sim_code", 32'(code), 32'd0);
    chk("sim_multi", 32'(multi), 32'd1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    keys = '0;
    tick(10);
    chk("sim_multi_sticky", 32'(multi), 32'd1);
    flags_clr = 1'b1;
    tick(1);
    flags_clr = 1'b0;
    chk("sim_multi_clr", 32'(multi), 32'd0);

    // async reset while an event is pending
    keys[6] = 1'b1;
    tick(7);
    chk("rm_valid", 32'(valid), 32'd1);
    chk("rm_code", 32'(code), 32'd6);
    #2;
    clear = 1'b1;
    #1;
    chk("rm_async_valid", 32'(valid), 32'd0);
    chk("rm_async_code", 32'(code), 32'd0);
    chk("rm_async_pressed", 32'(pressed), 32'd0);
    #2;
    clear = 1'b0;
    tick(6);
    chk("rm_e6_valid", 32'(valid), 32'd0);
    tick(1);
    chk("rm_e7_valid", 32'(valid), 32'd1);
    chk("rm_e7_code", 32'(code), 32'd6);
    keys = '0;
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
